spi_flash_reader: RTL and testbench

SPI flash read engine that sits directly upstream of the flash-to-SRAM copier. On a start pulse it issues a standard READ (0x03) command with a 24-bit byte address to the configuration flash, then streams back a requested number of 16-bit words over a valid/ready handshake. It stalls SCLK whenever the consumer applies backpressure, so no data is lost. It generates all SPI pins, including the flash reset line.

---
 rtl/spi_flash_reader.sv | 195 +++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: issues a SPI READ (0x03) with a 24-bit byte address, then
// streams back big-endian 16-bit words over a valid/ready handshake. SCLK is
// parked low while a finished word waits for the consumer, so no data is lost.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] start_addr,
    input  logic [16:0] word_count,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_rst_n
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CS_LAST  = CW'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD, S_CSUP
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;         // clocks into the current SCLK half-period
    logic [4:0]    bit_q, bit_d;         // bits completed in the current phase
    logic [31:0]   sh_q, sh_d;           // outgoing command + address
    logic [15:0]   rx_q, rx_d;           // incoming word being assembled
    logic [16:0]   cnt_q, cnt_d;         // words still to deliver
    logic [CW-1:0] cs_cnt_q, cs_cnt_d;   // CS_n high time before done
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          rst_n_q;
    logic [31:0]   cmd_word;
    logic          half_tick;

    assign cmd_word  = {8'h03, start_addr & 24'hFF_FFFE};
    assign half_tick = (div_q == DIV_LAST);

    // Next-state logic: SCLK generation, shifting and word handshake sequencing.
    always_comb begin
        // NOTE: every target gets a default here so no path leaves it unassigned (no latches).
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        cs_cnt_d = cs_cnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count == 17'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_CMD;
                        busy_d  = 1'b1;
                        cs_n_d  = 1'b0;
                        sh_d    = cmd_word;
                        mosi_d  = cmd_word[31];
                        cnt_d   = word_count;
                        div_d   = '0;
                        bit_d   = '0;
                        sclk_d  = 1'b0;
                    end
                end
            end

            S_CMD, S_ADDR, S_DATA: begin
                if (half_tick) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        // Rising edge: the flash's bit has been stable since the last fall.
                        if (state_q == S_DATA) rx_d = {rx_q[14:0], spi_miso};
                    end else begin
                        // Falling edge: advance MOSI and close out the bit.
                        bit_d  = bit_q + 5'd1;
                        sh_d   = {sh_q[30:0], 1'b0};
                        mosi_d = sh_q[30];
                        if (state_q == S_CMD && bit_q == 5'd7) begin
                            state_d = S_ADDR;
                        end else if (state_q == S_ADDR && bit_q == 5'd31) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else if (state_q == S_DATA && bit_q == 5'd15) begin
                            state_d = S_HOLD;
                            bit_d   = '0;
                            data_d  = rx_q;
                            valid_d = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            S_HOLD: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q - 17'd1;
                    if (cnt_q == 17'd1) begin
                        state_d  = S_CSUP;
                        cs_n_d   = 1'b1;
                        cs_cnt_d = '0;
                    end else begin
                        state_d = S_DATA;
                        div_d   = '0;
                    end
                end
            end

            S_CSUP: begin
                if (cs_cnt_q == CS_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cs_cnt_d = cs_cnt_q + CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset; flash reset follows ~rst.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
            cnt_q    <= '0;
            cs_cnt_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            rst_n_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
            cs_cnt_q <= cs_cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            rst_n_q  <= 1'b1;
        end
    end

    assign word_data  = data_q;
    assign word_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_clk    = sclk_q;
    assign spi_mosi   = mosi_q;
    assign spi_rst_n  = rst_n_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// Testbench for spi_flash_reader: a behavioural SPI flash answers the READ
// command from a byte array; words are predicted as big-endian byte pairs.
module tb_spi_flash_reader;
    localparam int CLK_DIV   = 2;
    localparam int CS_IDLE   = 4;
    localparam int FIRST_LAT = 1 + 96 * CLK_DIV;
    localparam int WORD_GAP  = 32 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] start_addr = '0;
    logic [16:0] word_count = '0;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        busy, done, spi_cs_n, spi_clk, spi_mosi, spi_rst_n;
    logic        spi_miso = 1'b0;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .done(done), .spi_cs_n(spi_cs_n),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_rst_n(spi_rst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash model: captures the 32 command/address bits on SCLK rises, then
    // presents data bytes MSB first, changing MISO on each SCLK fall.
    logic [7:0]  flash_bytes [0:255];
    logic [31:0] cmd_cap = '0;
    int          rises = 0;
    int          dbit = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;

    always @(spi_cs_n or spi_clk) begin
        if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
            rises = 0;
            dbit = 0;
            cmd_cap = '0;
        end
        if (spi_cs_n === 1'b0 && prev_sclk === 1'b0 && spi_clk === 1'b1) begin
            if (rises < 32) cmd_cap = {cmd_cap[30:0], spi_mosi};
            rises++;
        end
        if (spi_cs_n === 1'b0 && prev_sclk === 1'b1 && spi_clk === 1'b0 && rises >= 32) begin
            spi_miso = flash_bytes[(dbit / 8) % 256][7 - (dbit % 8)];
            dbit++;
        end
        prev_cs = spi_cs_n;
        prev_sclk = spi_clk;
    end

    task automatic fill_random();
        for (int i = 0; i < 256; i++) flash_bytes[i] = 8'($urandom);
    endtask

    // One complete transaction with optional random ready, a long stall on one
    // word, and an ignored start pulse in the middle of the first data word.
    task automatic run_xfer(input logic [23:0] addr, input int cnt, input bit rnd_ready,
                            input int stall_word, input int stall_len, input bit poke);
        int c0, widx, hs_cyc, done_cnt, done_cyc, cs_hi, stall_left, t, limit;
        bit fresh, rdy;
        logic [15:0] exp_word;
        logic [31:0] exp_cmd;
        exp_cmd = {8'h03, addr[23:1], 1'b0};
        @(negedge clk);
        start_addr = addr; word_count = 17'(cnt); start = 1'b1; word_ready = 1'b0;
        c0 = cyc;
        widx = 0; hs_cyc = c0; done_cnt = 0; done_cyc = -1; cs_hi = 0;
        stall_left = stall_len; t = 0; fresh = 1'b1; exp_word = '0;
        limit = 2000 + 400 * cnt + stall_len;
        @(negedge clk);
        start = 1'b0; start_addr = 24'($urandom); word_count = 17'($urandom_range(0, 9));
        while (t < limit && done_cnt == 0) begin
            start = poke && (cyc == c0 + 150);
            if (done === 1'b1) begin
                done_cnt++; done_cyc = cyc;
                n_vec++;
                if (busy !== 1'b0) begin n_err++; $display("FAIL busy_at_done: got %b want 0", busy); end
            end
            if (widx < cnt && spi_cs_n !== 1'b0) cs_hi++;
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (word_valid === 1'b1 && widx < cnt) begin
                exp_word = {flash_bytes[2 * widx], flash_bytes[2 * widx + 1]};
                if (fresh) begin
                    fresh = 1'b0;
                    n_vec++;
                    if (word_data !== exp_word) begin
                        n_err++; $display("FAIL word%0d_data: got %h want %h", widx, word_data, exp_word);
                    end
                    n_vec++;
                    if (widx == 0 && cyc - c0 != FIRST_LAT) begin
                        n_err++; $display("FAIL first_latency: got %0d want %0d", cyc - c0, FIRST_LAT);
                    end else if (widx > 0 && cyc - hs_cyc != WORD_GAP) begin
                        n_err++; $display("FAIL word%0d_gap: got %0d want %0d", widx, cyc - hs_cyc, WORD_GAP);
                    end
                    n_vec++;
                    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_in_xfer: got %b want 1", busy); end
                end
                if (widx == stall_word && stall_left > 0) begin
                    rdy = 1'b0; stall_left--;
                    n_vec++;
                    if (spi_clk !== 1'b0 || word_data !== exp_word) begin
                        n_err++;
                        $display("FAIL stall_hold: sclk %b data %h want sclk 0 data %h", spi_clk, word_data, exp_word);
                    end
                end
                if (rdy) begin hs_cyc = cyc; widx++; fresh = 1'b1; end
            end
            word_ready = rdy;
            @(negedge clk);
            t++;
        end
        word_ready = 1'b0; start = 1'b0;
        n_vec++;
        if (done_cnt != 1 || widx != cnt) begin
            n_err++; $display("FAIL completion: words %0d done %0d want words %0d done 1", widx, done_cnt, cnt);
        end
        n_vec++;
        if (done_cyc - hs_cyc != CS_IDLE + 1) begin
            n_err++; $display("FAIL done_delay: got %0d want %0d", done_cyc - hs_cyc, CS_IDLE + 1);
        end
        n_vec++;
        if (cs_hi != 0) begin n_err++; $display("FAIL cs_low_burst: high cycles %0d want 0", cs_hi); end
        n_vec++;
        if (cmd_cap !== exp_cmd) begin n_err++; $display("FAIL mosi_cmd: got %h want %h", cmd_cap, exp_cmd); end
        n_vec++;
        if (rises != 32 + 16 * cnt) begin
            n_err++; $display("FAIL sclk_rises: got %0d want %0d", rises, 32 + 16 * cnt);
        end
        n_vec++;
        if (done !== 1'b0 || spi_cs_n !== 1'b1) begin
            n_err++; $display("FAIL after_done: done %b cs_n %b want 0 1", done, spi_cs_n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({spi_cs_n, spi_clk, spi_mosi, spi_rst_n, word_valid, busy, done, word_data} !== {7'b1000000, 16'h0}) begin
            n_err++;
            $display("FAIL reset_state: cs_n %b sclk %b mosi %b rst_n %b valid %b busy %b done %b data %h",
                     spi_cs_n, spi_clk, spi_mosi, spi_rst_n, word_valid, busy, done, word_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (spi_rst_n !== 1'b1 || spi_cs_n !== 1'b1) begin
            n_err++; $display("FAIL reset_release: rst_n %b cs_n %b want 1 1", spi_rst_n, spi_cs_n);
        end
    endtask

    task automatic test_single_word();
        fill_random();
        flash_bytes[0] = 8'hA5; flash_bytes[1] = 8'h3C;
        run_xfer(24'h100000, 1, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) flash_bytes[i] = 8'(i);
        run_xfer(24'h000000, 4, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_random();
        run_xfer(24'($urandom), 4, 1'b0, 1, 50, 1'b0);
    endtask

    task automatic test_zero_count();
        int c0;
        @(negedge clk);
        start_addr = 24'($urandom); word_count = 17'd0; start = 1'b1; c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1 || cyc - c0 != 1) begin n_err++; $display("FAIL zero_done: got %b want 1", done); end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
                n_err++; $display("FAIL zero_idle: cs_n %b busy %b want 1 0", spi_cs_n, busy);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin n_err++; $display("FAIL zero_single_done: got %b want 0", done); end
        end
    endtask

    task automatic test_reset_mid_addr();
        int t;
        fill_random();
        @(negedge clk);
        start_addr = 24'($urandom); word_count = 17'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (rises < 18 && t < 1000) begin @(negedge clk); t++; end
        n_vec++;
        if (rises < 18) begin n_err++; $display("FAIL reach_addr_bit: rises %0d want 18", rises); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({spi_cs_n, spi_clk, spi_rst_n, busy, word_valid, spi_mosi} !== 6'b100000) begin
            n_err++;
            $display("FAIL mid_reset: cs_n %b sclk %b rst_n %b busy %b valid %b mosi %b want 1 0 0 0 0 0",
                     spi_cs_n, spi_clk, spi_rst_n, busy, word_valid, spi_mosi);
        end
        rst = 1'b0;
        @(negedge clk);
        run_xfer(24'($urandom), 2, 1'b0, -1, 0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        fill_random();
        run_xfer(24'($urandom), 2, 1'b0, -1, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_xfer(24'($urandom) | 24'h1, $urandom_range(1, 5), 1'b1, -1, 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_zero_count();
        test_reset_mid_addr();
        test_start_while_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
